wb_spi_req_slave: RTL

//  Wishbone B3 classic slave in front of the SPI memory master. Each WB access becomes one
//  32-bit command word, written via port A into the shared 256x32 request buffer. The SPI

---
 rtl/spi_buf_pkg.sv | 34 +++
 rtl/wb_spi_poll_timer.sv | 40 ++++
 rtl/wb_spi_req_slave.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_buf_pkg.sv
// Request-buffer command word layout and slave FSM states, shared by the WB
// request slave and the SPI master that executes the commands.
package spi_buf_pkg;

  localparam int BIT_DONE = 31;
  localparam int BIT_PEND = 30;
  localparam int BIT_RD   = 29;
  localparam int DATA_HI  = 14;
  localparam int DATA_LO  = 7;
  localparam int ADDR_HI  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_POLL,
    ST_RELEASE,
    ST_ACK
  } state_e;

  // Pending command word; the read flag selects the SPI direction.
  function automatic logic [31:0] make_cmd(input logic       rd,
                                           input logic [7:0] data,
                                           input logic [6:0] addr);
    logic [31:0] w;
    w                   = '0;
    w[BIT_PEND]         = 1'b1;
    w[BIT_RD]           = rd;
    w[DATA_HI:DATA_LO]  = data;
    w[ADDR_HI:0]        = addr;
    return w;
  endfunction

endpackage

// File: rtl/wb_spi_poll_timer.sv
// Poll timeout counter: cleared before polling starts, counts poll cycles and
// flags the last permitted one.
module wb_spi_poll_timer #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Counter saturates on its last value; expired_o marks the final poll cycle.
  assign expired_o = (count_q == LAST_CNT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_spi_req_slave.sv
// Wishbone classic slave that turns each access into a command word in the
// shared request buffer, polls the slot for completion, frees it and acks.
module wb_spi_req_slave
  import spi_buf_pkg::*;
#(
  parameter int          BUF_AW      = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [8:0]        wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [BUF_AW-1:0] buf_addra,
  output logic [31:0]       buf_dina,
  output logic              buf_wea,
  input  logic [31:0]       buf_douta,
  output logic              busy_o
);

  state_e              state_q,     state_d;
  logic [BUF_AW-1:0]   ptr_q,       ptr_d;
  logic                we_q,        we_d;
  logic [6:0]          addr_q,      addr_d;
  logic [7:0]          data_q,      data_d;
  logic                fail_q,      fail_d;
  logic [7:0]          rd_byte_q,   rd_byte_d;
  logic [31:0]         wb_dat_q,    wb_dat_d;
  logic                ack_q,       ack_d;
  logic                err_q,       err_d;
  logic [BUF_AW-1:0]   buf_addra_q, buf_addra_d;
  logic [31:0]         buf_dina_q,  buf_dina_d;
  logic                buf_wea_q,   buf_wea_d;
  logic                busy_q,      busy_d;
  logic                tmr_expired;

  logic unused_inputs;
  assign unused_inputs = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8],
                           buf_douta[30:15], buf_douta[6:0]};

  wb_spi_poll_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_poll_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_WAIT),
    .en_i      (state_q == ST_POLL),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fail_d      = fail_q;
    rd_byte_d   = rd_byte_q;
    buf_addra_d = buf_addra_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d        = wb_we_i;
          addr_d      = wb_adr_i[8:2];
          data_d      = wb_we_i ? wb_dat_i[7:0] : 8'h00;
          fail_d      = 1'b0;
          rd_byte_d   = 8'h00;
          buf_addra_d = ptr_q;
          // A write with no byte lane enabled has nothing to send to SPI.
          state_d     = (wb_we_i && !wb_sel_i[0]) ? ST_ACK : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d   = ptr_q + BUF_AW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (buf_douta[BIT_DONE]) begin
          rd_byte_d = buf_douta[DATA_HI:DATA_LO];
          state_d   = ST_RELEASE;
        end else if (tmr_expired) begin
          fail_d  = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    buf_wea_d  = (state_d == ST_ISSUE) || (state_d == ST_RELEASE);
    buf_dina_d = (state_d == ST_ISSUE) ? make_cmd(!we_d, data_d, addr_d) : 32'h0;
    ack_d      = (state_d == ST_ACK) && wb_cyc_i && !fail_d;
    err_d      = (state_d == ST_ACK) && wb_cyc_i && fail_d;
    wb_dat_d   = ((state_d == ST_ACK) && !we_d) ? {24'h0, rd_byte_d} : 32'h0;
    busy_d     = (state_d != ST_IDLE);
  end

  // The request buffer sits outside this block, so reset never touches its
  // contents; a slot pending at reset stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      fail_q      <= 1'b0;
      rd_byte_q   <= '0;
      wb_dat_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      buf_addra_q <= '0;
      buf_dina_q  <= '0;
      buf_wea_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      fail_q      <= fail_d;
      rd_byte_q   <= rd_byte_d;
      wb_dat_q    <= wb_dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      buf_addra_q <= buf_addra_d;
      buf_dina_q  <= buf_dina_d;
      buf_wea_q   <= buf_wea_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_dat_o  = wb_dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign buf_addra = buf_addra_q;
  assign buf_dina  = buf_dina_q;
  assign buf_wea   = buf_wea_q;
  assign busy_o    = busy_q;

endmodule
